apb_requester: RTL and testbench

- APB4 requester (initiator) that drives the register-block responder whose fields (rw, rwa, ro) are written and read over APB.
- Converts a single-outstanding valid/ready command interface into compliant SETUP/ACCESS bus cycles.
- Returns one self-clearing response pulse per command, carrying read data, slave error and timeout status.
- Sits between a local controller or test sequencer and the APB register slave.

---
 rtl/apb_requester_if.sv | 44 ++++
 rtl/apb_requester.sv | 117 +++++++++++
 tb/tb_apb_requester.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_if.sv
// Command, response and APB bus bundle for the APB4 requester.
// The master modport is the requester's view; slave is the environment's.
interface apb_requester_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;
    logic [DWIDTH/8-1:0] cmd_strb;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH/8-1:0] pstrb;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: one outstanding valid/ready command mapped onto
// SETUP/ACCESS cycles, with a single-cycle response pulse and timeout.
module apb_requester #(
    parameter int TP      = 1,
    parameter int AWIDTH  = 16,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input logic             clk,
    input logic             rst_n,
    apb_requester_if.master bus
);
    localparam int SW = DWIDTH / 8;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST =
        CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    if ((DWIDTH % 8) != 0 || TP < 0) begin : g_bad_param
        $error("apb_requester: DWIDTH must be a multiple of 8");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]     wait_cnt;
    logic              pwrite_q;
    logic [AWIDTH-1:0] paddr_q;
    logic [DWIDTH-1:0] pwdata_q;
    logic [SW-1:0]     pstrb_q;
    logic              rsp_valid_q;
    logic [DWIDTH-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              rsp_timeout_q;

    logic accept;
    logic done;
    logic abort;
    logic tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (wait_cnt == TMO_LAST);
    assign accept  = bus.cmd_valid && (state == IDLE);
    assign done    = (state == ACCESS) && bus.pready;
    // Completion wins over timeout when both land in the same cycle.
    assign abort   = (state == ACCESS) && !bus.pready && tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done || abort) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= done || abort;
            if (accept) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
                pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && !bus.pready
                         && wait_cnt != '1) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (done) begin
                rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                rsp_err_q     <= bus.pslverr;
                rsp_timeout_q <= 1'b0;
            end else if (abort) begin
                rsp_rdata_q   <= '0;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = (state == IDLE);
    assign bus.psel        = (state != IDLE);
    assign bus.penable     = (state == ACCESS);
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: write, waited read, slave error,
// timeout, back-to-back commands and reset during ACCESS.
module tb_apb_requester;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    apb_requester_if #(.AWIDTH(16), .DWIDTH(32)) bus ();

    apb_requester #(
        .TP(1), .AWIDTH(16), .DWIDTH(32), .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_strb  = s;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b0;
        step();
        step();
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.paddr, 0);
        rst_n = 1'b1;
        step();

        // write, zero wait states
        cmd(1'b1, 16'h0010, 32'hA5A5_0001, 4'hF);
        chk("wr_ready_T", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        chk("wr_psel_T1", bus.psel, 1);
        chk("wr_pen_T1", bus.penable, 0);
        chk("wr_ready_T1", bus.cmd_ready, 0);
        step();
        chk("wr_pen_T2", bus.penable, 1);
        chk("wr_paddr", bus.paddr, 16'h0010);
        chk("wr_pwdata", bus.pwdata, 32'hA5A5_0001);
        chk("wr_pstrb", bus.pstrb, 4'hF);
        chk("wr_pwrite", bus.pwrite, 1);
        step();
        chk("wr_rsp_valid", bus.rsp_valid, 1);
        chk("wr_rsp_err", bus.rsp_err, 0);
        chk("wr_rsp_rdata", bus.rsp_rdata, 0);
        chk("wr_psel_T3", bus.psel, 0);
        chk("wr_ready_T3", bus.cmd_ready, 1);
        step();
        chk("wr_rsp_pulse", bus.rsp_valid, 0);

        // read with three wait states
        bus.pready = 1'b0;
        cmd(1'b0, 16'h0020, 32'hDEAD_BEEF, 4'hF);
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("rd_pstrb", bus.pstrb, 0);
        chk("rd_pwdata", bus.pwdata, 0);
        chk("rd_pwrite", bus.pwrite, 0);
        for (int i = 0; i < 3; i++) begin
            bus.prdata = 32'hBAD0_0000 + 32'(i);
            chk("rd_wait_pen", bus.penable, 1);
            chk("rd_wait_paddr", bus.paddr, 16'h0020);
            step();
            chk("rd_wait_norsp", bus.rsp_valid, 0);
        end
        bus.pready = 1'b1;
        bus.prdata = 32'h1234_5678;
        chk("rd_last_pen", bus.penable, 1);
        chk("rd_last_paddr", bus.paddr, 16'h0020);
        step();
        bus.prdata = '0;
        chk("rd_rsp_valid", bus.rsp_valid, 1);
        chk("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
        chk("rd_rsp_err", bus.rsp_err, 0);
        chk("rd_rsp_tmo", bus.rsp_timeout, 0);
        step();
        chk("rd_hold_rdata", bus.rsp_rdata, 32'h1234_5678);

        // pslverr during a wait cycle is ignored
        bus.pready = 1'b0;
        cmd(1'b0, 16'h0030, 32'h0, 4'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        bus.pslverr = 1'b1;
        step();
        bus.pslverr = 1'b0;
        bus.pready  = 1'b1;
        bus.prdata  = 32'h0000_0077;
        step();
        chk("werr_rsp_valid", bus.rsp_valid, 1);
        chk("werr_rsp_err", bus.rsp_err, 0);
        chk("werr_rdata", bus.rsp_rdata, 32'h77);

        // pslverr on the ready cycle
        cmd(1'b0, 16'h0034, 32'h0, 4'h0);
        bus.prdata = 32'hCAFE_0001;
        step();
        bus.cmd_valid = 1'b0;
        step();
        bus.pslverr = 1'b1;
        step();
        bus.pslverr = 1'b0;
        chk("serr_rsp_valid", bus.rsp_valid, 1);
        chk("serr_rsp_err", bus.rsp_err, 1);
        chk("serr_rsp_tmo", bus.rsp_timeout, 0);
        chk("serr_rdata", bus.rsp_rdata, 32'hCAFE_0001);
        bus.prdata = '0;
        step();

        // timeout after 16 ACCESS cycles
        bus.pready = 1'b0;
        cmd(1'b0, 16'h0040, 32'h0, 4'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        for (int i = 1; i < 16; i++) begin
            step();
        end
        chk("tmo_pen_16", bus.penable, 1);
        chk("tmo_norsp_16", bus.rsp_valid, 0);
        step();
        chk("tmo_psel", bus.psel, 0);
        chk("tmo_rsp_valid", bus.rsp_valid, 1);
        chk("tmo_rsp_err", bus.rsp_err, 1);
        chk("tmo_rsp_tmo", bus.rsp_timeout, 1);
        chk("tmo_rdata", bus.rsp_rdata, 0);
        step();

        // ready on the 16th cycle: normal completion
        cmd(1'b0, 16'h0044, 32'h0, 4'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        for (int i = 1; i < 16; i++) begin
            step();
        end
        bus.pready = 1'b1;
        bus.prdata = 32'h5555_AAAA;
        step();
        bus.prdata = '0;
        chk("tmo16_rsp_valid", bus.rsp_valid, 1);
        chk("tmo16_rsp_err", bus.rsp_err, 0);
        chk("tmo16_rsp_tmo", bus.rsp_timeout, 0);
        chk("tmo16_rdata", bus.rsp_rdata, 32'h5555_AAAA);
        step();

        // back-to-back with cmd_valid held
        cmd(1'b1, 16'h0050, 32'h1111_1111, 4'h3);
        step();
        cmd(1'b1, 16'h0054, 32'h2222_2222, 4'hC);
        chk("b2b_ready_T1", bus.cmd_ready, 0);
        step();
        chk("b2b_paddr1", bus.paddr, 16'h0050);
        chk("b2b_pstrb1", bus.pstrb, 4'h3);
        step();
        chk("b2b_rsp1", bus.rsp_valid, 1);
        chk("b2b_ready_T3", bus.cmd_ready, 1);
        step();
        bus.cmd_valid = 1'b0;
        chk("b2b_psel2", bus.psel, 1);
        chk("b2b_pen2", bus.penable, 0);
        chk("b2b_paddr2", bus.paddr, 16'h0054);
        chk("b2b_pwdata2", bus.pwdata, 32'h2222_2222);
        step();
        chk("b2b_access2", bus.penable, 1);
        step();
        chk("b2b_rsp2", bus.rsp_valid, 1);
        step();

        // reset asserted during ACCESS
        bus.pready = 1'b0;
        cmd(1'b0, 16'h0060, 32'h0, 4'h0);
        step();
        bus.cmd_valid = 1'b0;
        step();
        chk("rmid_pen", bus.penable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_psel", bus.psel, 0);
        chk("rmid_penable", bus.penable, 0);
        chk("rmid_rsp", bus.rsp_valid, 0);
        bus.pready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rmid_norsp", bus.rsp_valid, 0);
            chk("rmid_ready", bus.cmd_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
